// File: rtl/majority_tx_scheduler.sv
// rtl/majority_tx_scheduler.sv - two-requester round-robin scheduler with majority-info encoder and serializer
module majority_tx_scheduler #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [6:0] data_a,
  input  logic [6:0] data_b,
  input  logic       control_a,
  input  logic       control_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       ser_out,
  output logic       ser_valid,
  output logic [7:0] data_out,
  output logic       src,
  output logic       busy,
  output logic       done,
  output logic [7:0] word_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        last_grant_b;

  logic        pick_b;
  logic [6:0]  sel_data;
  logic        sel_ctrl;
  logic [2:0]  ones;
  logic        info;
  logic [7:0]  enc_word;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick_b   = req_b & (~req_a | ~last_grant_b);
    sel_data = pick_b ? data_b : data_a;
    sel_ctrl = pick_b ? control_b : control_a;
    ones     = 3'd0;
    for (int i = 0; i < 7; i++) begin
      ones = ones + {2'b00, sel_data[i]};
    end
    info     = sel_ctrl ? (ones >= 3'd4) : (ones <= 3'd3);
    enc_word = {sel_data[6:4], info, sel_data[3:0]};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_a | req_b) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    if (state == SHIFT) begin
      ser_valid = 1'b1;
      ser_out   = MSB_FIRST ? shreg[7] : shreg[0];
    end
    if (state != IDLE) busy = 1'b1;
    if (state == DONE) done = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_a        <= 1'b0;
      gnt_b        <= 1'b0;
      data_out     <= 8'h00;
      src          <= 1'b0;
      shreg        <= 8'h00;
      bit_cnt      <= 3'd0;
      word_cnt     <= 8'h00;
      last_grant_b <= 1'b1;
    end else begin
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      case (state)
        IDLE: begin
          if (req_a | req_b) begin
            gnt_a        <= ~pick_b;
            gnt_b        <= pick_b;
            last_grant_b <= pick_b;
            src          <= pick_b;
            data_out     <= enc_word;
            shreg        <= enc_word;
            bit_cnt      <= 3'd0;
          end
        end
        SHIFT: begin
          bit_cnt <= bit_cnt + 3'd1;
          shreg   <= MSB_FIRST ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};
          if (bit_cnt == 3'd7) word_cnt <= word_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_majority_tx_scheduler.sv
// tb/tb_majority_tx_scheduler.sv - directed bench with word-timeline model for majority_tx_scheduler
module tb_majority_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b, control_a, control_b;
  logic [6:0] data_a, data_b;

  logic       gnt_a, gnt_b, ser_out, ser_valid, src, busy, done;
  logic [7:0] data_out, word_cnt;
  logic       gnt_a_l, gnt_b_l, ser_out_l, ser_valid_l, src_l, busy_l, done_l;
  logic [7:0] data_out_l, word_cnt_l;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int cap_time = 0;
  int cap_prev = 0;
  logic [7:0] seq_m, seq_l;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  majority_tx_scheduler u_msb (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b), .control_a(control_a), .control_b(control_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .ser_out(ser_out), .ser_valid(ser_valid),
    .data_out(data_out), .src(src), .busy(busy), .done(done), .word_cnt(word_cnt)
  );

  majority_tx_scheduler #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b), .control_a(control_a), .control_b(control_b),
    .gnt_a(gnt_a_l), .gnt_b(gnt_b_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
    .data_out(data_out_l), .src(src_l), .busy(busy_l), .done(done_l), .word_cnt(word_cnt_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: a word is a timeline of 9 cycles after capture (8 bits, then done).
  int         m_since;
  logic [7:0] m_word;
  logic       m_src, m_last_b;
  logic [7:0] m_cnt;

  function automatic logic [7:0] encode(input logic [6:0] d, input logic c);
    int n1;
    logic inf;
    n1  = $countones(d);
    inf = c ? (n1 > 7 - n1) : ((7 - n1) > n1);
    return {d[6:4], inf, d[3:0]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_since = 0; m_word = 8'h00; m_src = 1'b0; m_last_b = 1'b1; m_cnt = 8'h00;
    end else if (m_since == 0) begin
      if (req_a || req_b) begin
        m_src    = req_a && req_b ? !m_last_b : req_b;
        m_last_b = m_src;
        m_word   = m_src ? encode(data_b, control_b) : encode(data_a, control_a);
        m_since  = 1;
      end
    end else if (m_since < 9) begin
      m_since++;
      if (m_since == 9) m_cnt = m_cnt + 8'd1;
    end else begin
      m_since = 0;
    end
  end

  always @(negedge clk) begin
    logic sv;
    sv = (m_since >= 1) && (m_since <= 8);
    check("gnt_a",     gnt_a,     m_since == 1 && !m_src);
    check("gnt_b",     gnt_b,     m_since == 1 && m_src);
    check("ser_valid", ser_valid, sv);
    check("ser_out",   ser_out,   sv ? m_word[8 - m_since] : 1'b0);
    check("ser_out_l", ser_out_l, sv ? m_word[m_since - 1] : 1'b0);
    check("done",      done,      m_since == 9);
    check("busy",      busy,      m_since != 0);
    check("data_out",  data_out,  m_word);
    check("src",       src,       m_src);
    check("word_cnt",  word_cnt,  m_cnt);
    check("lsb_same",  {gnt_a_l, gnt_b_l, ser_valid_l, done_l, busy_l, src_l, data_out_l, word_cnt_l},
                       {gnt_a, gnt_b, ser_valid, done, busy, src, data_out, word_cnt});
  end

  task automatic run_word(input string tag, input logic exp_src, input logic [7:0] exp_data, input bit drop);
    int n;
    n = 0;
    while (!(gnt_a || gnt_b) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_gnt_seen"}, n < 40, 1);
    check({tag, "_gnt_b"}, gnt_b, exp_src);
    check({tag, "_data_out"}, data_out, exp_data);
    check({tag, "_src"}, src, exp_src);
    cap_prev = cap_time;
    cap_time = cyc;
    if (drop) begin
      if (gnt_a) req_a = 1'b0;
      if (gnt_b) req_b = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      seq_m[7 - i] = ser_out;
      seq_l[7 - i] = ser_out_l;
      if (i < 7) @(negedge clk);
    end
    @(negedge clk);
    check({tag, "_done"}, done, 1);
  endtask

  initial begin
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0; control_a = 1'b0; control_b = 1'b0;
    data_a = 7'h00; data_b = 7'h00;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_word_cnt", word_cnt, 8'h00);
    check("rst_ser", {ser_out, ser_valid, done, gnt_a, gnt_b, src}, 6'b0);
    rst = 1'b0;

    // Only A
    data_a = 7'b0000001; control_a = 1'b0; req_a = 1'b1;
    run_word("only_a", 1'b0, 8'h11, 1'b1);
    check("only_a_seq_msb", seq_m, 8'b0001_0001);
    check("only_a_seq_lsb", seq_l, 8'b1000_1000);
    check("only_a_cnt", word_cnt, 8'd1);

    // Polarity on B
    data_b = 7'b1111110; control_b = 1'b1; req_b = 1'b1;
    run_word("pol_b1", 1'b1, 8'hFE, 1'b1);
    control_b = 1'b0; req_b = 1'b1;
    run_word("pol_b0", 1'b1, 8'hEE, 1'b1);
    check("pol_cnt", word_cnt, 8'd3);

    // Fairness with both held
    data_a = 7'h55; data_b = 7'h55; control_a = 1'b0; control_b = 1'b0;
    req_a = 1'b1; req_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_word("fair", k[0], 8'hA5, 1'b0);
      if (k > 0) check("fair_period", cap_time - cap_prev, 10);
    end
    req_a = 1'b0; req_b = 1'b0;
    repeat (3) @(negedge clk);
    check("fair_idle", busy, 0);
    check("fair_cnt", word_cnt, 8'd7);

    // Reset in the middle of a word
    data_a = 7'b0110011; control_a = 1'b1; req_a = 1'b1;
    run_word("pre_abort", 1'b0, encode(7'b0110011, 1'b1), 1'b1);
    req_a = 1'b1;
    while (!gnt_a && cyc < 5000) @(negedge clk);
    req_a = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ser_valid", ser_valid, 0);
    check("abort_outs", {ser_out, done, gnt_a, gnt_b, src}, 5'b0);
    check("abort_data_out", data_out, 8'h00);
    check("abort_word_cnt", word_cnt, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_cnt_after", word_cnt, 8'h00);
    check("abort_idle", busy, 0);

    // Wrap of the word counter
    data_a = 7'b0000001; control_a = 1'b0; req_a = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      run_word("wrap", 1'b0, 8'h11, 1'b0);
      if (k == 255) check("wrap_255", word_cnt, 8'hFF);
      if (k == 256) check("wrap_256", word_cnt, 8'h00);
    end
    req_a = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
